// File: rtl/keypad_bcd_ctrl.sv
// Decimal keypad front end: synchronizes ten raw key lines, debounces a
// press, converts a single pressed key to its BCD digit and queues it in a
// small show-ahead FIFO for a ready/valid consumer. Multi-key presses are
// flagged on o_err, and codes that find the FIFO full are flagged on o_ovf.
module keypad_bcd_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic [9:0]                    i_keys,
    input  logic                          i_ready,
    output logic                          o_valid,
    output logic [3:0]                    o_bcd,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_err,
    output logic                          o_ovf
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [7:0]    CNT_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_HOLD
    } state_t;

    // Index of the highest set key; only meaningful for a one-hot input.
    function automatic logic [3:0] f_key_to_bcd(input logic [9:0] keys);
        logic [3:0] idx;
        idx = 4'd0;
        for (int n = 0; n < 10; n++) begin
            if (keys[n]) idx = 4'(n);
        end
        return idx;
    endfunction

    // Exactly one key line set.
    function automatic logic f_is_onehot(input logic [9:0] keys);
        return (keys != 10'd0) && ((keys & (keys - 10'd1)) == 10'd0);
    endfunction

    logic [9:0]    r_sync_s1;
    logic [9:0]    r_sync_s2;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_cnt;
    logic [7:0]    w_cnt_nxt;
    logic [9:0]    r_cap;
    logic [9:0]    w_cap_nxt;
    logic          w_push;
    logic          w_err;
    logic [3:0]    w_push_bcd;

    logic [3:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_pop;
    logic          w_accept;
    logic          r_err;
    logic          r_ovf;

    // Two-flop synchronizer for the asynchronous key lines.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync_s1 <= 10'd0;
            r_sync_s2 <= 10'd0;
        end else begin
            r_sync_s1 <= i_keys;
            r_sync_s2 <= r_sync_s1;
        end
    end

    // Scan FSM state, debounce counter and capture register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_cap   <= 10'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cap   <= w_cap_nxt;
        end
    end

    // Next-state logic; in HOLD the counter tracks consecutive released samples.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cap_nxt   = r_cap;
        w_push      = 1'b0;
        w_err       = 1'b0;
        w_push_bcd  = f_key_to_bcd(r_cap);
        if (!i_en) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_sync_s2 != 10'd0) begin
                        w_state_nxt = ST_DEBOUNCE;
                        w_cap_nxt   = r_sync_s2;
                        w_cnt_nxt   = 8'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (r_sync_s2 == 10'd0) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 8'd0;
                    end else if (r_sync_s2 != r_cap) begin
                        w_cap_nxt = r_sync_s2;
                        w_cnt_nxt = 8'd1;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = 8'd0;
                        if (f_is_onehot(r_cap)) w_push = 1'b1;
                        else                    w_err  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (r_sync_s2 != 10'd0) begin
                        w_cnt_nxt = 8'd0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    // FIFO handshake: a pop frees a slot in the same cycle, so a full FIFO
    // can still take a push when the consumer is draining.
    always_comb begin
        w_pop       = (r_count != '0) && i_ready;
        w_accept    = w_push && ((r_count != COUNT_FULL) || w_pop);
        w_count_nxt = r_count;
        case ({w_accept, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage; contents need no reset since o_bcd is masked when empty.
    always_ff @(posedge i_clk) begin
        if (w_accept) r_mem[r_wr_ptr] <= w_push_bcd;
    end

    // FIFO pointers, occupancy and one-cycle status pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_err   <= w_err;
            r_ovf   <= w_push && !w_accept;
        end
    end

    assign o_valid = (r_count != '0);
    assign o_bcd   = o_valid ? r_mem[r_rd_ptr] : 4'b0000;
    assign o_count = r_count;
    assign o_err   = r_err;
    assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_keypad_bcd_ctrl.sv
// Directed bench for keypad_bcd_ctrl at default parameters (4-cycle debounce,
// 4-entry FIFO). Inputs change and outputs are sampled 1 time unit after
// each rising edge.
module tb_keypad_bcd_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic [9:0] keys;
    logic       ready;
    logic       valid;
    logic [3:0] bcd;
    logic [2:0] count;
    logic       err;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    keypad_bcd_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (4)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_keys  (keys),
        .i_ready (ready),
        .o_valid (valid),
        .o_bcd   (bcd),
        .o_count (count),
        .o_err   (err),
        .o_ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a key pattern long enough to be accepted, then release until idle.
    task automatic press(input logic [9:0] m);
        keys = m;
        repeat (7) tick();
        keys = 10'd0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; keys = 10'd0; ready = 1'b0;
        #3;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (bcd !== 4'd0)   begin failures++; $display("FAIL reset_bcd got=%0d exp=0", bcd); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (err !== 1'b0)   begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (ovf !== 1'b0)   begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_key();
        ready = 1'b0;
        keys = 10'b00_1000_0000;
        repeat (5) tick();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL k7_valid_edge5 got=%b exp=0", valid); end
        tick();
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL k7_valid_edge6 got=%b exp=1", valid); end
        checks++; if (bcd !== 4'd7)   begin failures++; $display("FAIL k7_bcd got=%0d exp=7", bcd); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL k7_count got=%0d exp=1", count); end
        repeat (12) tick();
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL k7_held_count got=%0d exp=1", count); end
        keys = 10'd0;
        repeat (8) tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL k7_drain_valid got=%b exp=0", valid); end
        checks++; if (bcd !== 4'd0)   begin failures++; $display("FAIL k7_empty_bcd got=%0d exp=0", bcd); end
    endtask

    task automatic test_glitch();
        int errs;
        errs = 0;
        keys = 10'b00_0000_1000;
        tick(); if (err) errs++;
        tick(); if (err) errs++;
        keys = 10'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (err) errs++;
        end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL glitch_count got=%0d exp=0", count); end
        checks++; if (errs != 0)      begin failures++; $display("FAIL glitch_err got=%0d exp=0", errs); end
        // A fresh press must see full-latency timing from IDLE; key 0 is the low boundary.
        keys = 10'b00_0000_0001;
        repeat (5) tick();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL k0_valid_edge5 got=%b exp=0", valid); end
        tick();
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL k0_valid_edge6 got=%b exp=1", valid); end
        checks++; if (bcd !== 4'd0)   begin failures++; $display("FAIL k0_bcd got=%0d exp=0", bcd); end
        keys = 10'd0;
        repeat (8) tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL k0_drain_count got=%0d exp=0", count); end
    endtask

    task automatic test_multikey();
        int errs;
        int err_edge;
        errs = 0; err_edge = 0;
        keys = 10'b00_0010_0100;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (err) begin errs++; err_edge = e; end
        end
        checks++; if (errs != 1)      begin failures++; $display("FAIL multi_err_pulses got=%0d exp=1", errs); end
        checks++; if (err_edge != 6)  begin failures++; $display("FAIL multi_err_edge got=%0d exp=6", err_edge); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL multi_count got=%0d exp=0", count); end
        keys = 10'd0;
        repeat (8) tick();
        press(10'b10_0000_0000);
        checks++; if (bcd !== 4'd9)   begin failures++; $display("FAIL k9_bcd got=%0d exp=9", bcd); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL k9_count got=%0d exp=1", count); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_overflow();
        int ovfs;
        logic [3:0] exp_q [4];
        exp_q[0] = 4'd1; exp_q[1] = 4'd2; exp_q[2] = 4'd3; exp_q[3] = 4'd4;
        ovfs = 0;
        ready = 1'b0;
        press(10'b00_0000_0010);
        press(10'b00_0000_0100);
        press(10'b00_0000_1000);
        press(10'b00_0001_0000);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_fill_count got=%0d exp=4", count); end
        keys = 10'b00_0100_0000;
        for (int i = 0; i < 15; i++) begin
            if (i == 7) keys = 10'd0;
            tick();
            if (ovf) ovfs++;
        end
        checks++; if (ovfs != 1)      begin failures++; $display("FAIL ovf_pulses got=%0d exp=1", ovfs); end
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bcd !== exp_q[i]) begin failures++; $display("FAIL ovf_drain_%0d got=%0d exp=%0d", i, bcd, exp_q[i]); end
            tick();
        end
        ready = 1'b0;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ovf_drain_empty got=%b exp=0", valid); end
    endtask

    task automatic test_back_to_back();
        int ovfs;
        logic [3:0] exp_q [4];
        exp_q[0] = 4'd2; exp_q[1] = 4'd3; exp_q[2] = 4'd4; exp_q[3] = 4'd8;
        ovfs = 0;
        ready = 1'b0;
        press(10'b00_0000_0010);
        press(10'b00_0000_0100);
        press(10'b00_0000_1000);
        press(10'b00_0001_0000);
        keys = 10'b01_0000_0000;
        repeat (5) tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL pp_count got=%0d exp=4", count); end
        checks++; if (ovf !== 1'b0)   begin failures++; $display("FAIL pp_ovf got=%b exp=0", ovf); end
        for (int i = 0; i < 9; i++) begin
            if (i == 1) keys = 10'd0;
            tick();
            if (ovf) ovfs++;
        end
        checks++; if (ovfs != 0) begin failures++; $display("FAIL pp_late_ovf got=%0d exp=0", ovfs); end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bcd !== exp_q[i]) begin failures++; $display("FAIL pp_drain_%0d got=%0d exp=%0d", i, bcd, exp_q[i]); end
            tick();
        end
        ready = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL pp_drain_count got=%0d exp=0", count); end
    endtask

    task automatic test_enable();
        ready = 1'b0;
        en = 1'b0;
        press(10'b00_0001_0000);
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL en_off_count got=%0d exp=0", count); end
        // Dropping enable mid-debounce restarts the press from scratch.
        en = 1'b1;
        keys = 10'b00_0010_0000;
        repeat (4) tick();
        en = 1'b0;
        tick();
        en = 1'b1;
        repeat (3) tick();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL en_restart_early got=%b exp=0", valid); end
        repeat (5) tick();
        checks++; if (bcd !== 4'd5)   begin failures++; $display("FAIL en_restart_bcd got=%0d exp=5", bcd); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL en_restart_count got=%0d exp=1", count); end
        keys = 10'd0;
        repeat (8) tick();
        en = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        en = 1'b1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL en_off_pop got=%0d exp=0", count); end
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        press(10'b00_0010_0000);
        press(10'b00_0100_0000);
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL rm_fill got=%0d exp=2", count); end
        keys = 10'b00_1000_0000;
        repeat (4) tick();
        rst = 1'b1;
        #2;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", valid); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rm_count got=%0d exp=0", count); end
        checks++; if (bcd !== 4'd0)   begin failures++; $display("FAIL rm_bcd got=%0d exp=0", bcd); end
        tick();
        rst = 1'b0;
        repeat (5) tick();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rm_edge5 got=%b exp=0", valid); end
        tick();
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL rm_edge6_count got=%0d exp=1", count); end
        checks++; if (bcd !== 4'd7)   begin failures++; $display("FAIL rm_edge6_bcd got=%0d exp=7", bcd); end
        keys = 10'd0;
        repeat (8) tick();
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_glitch();
        test_multikey();
        test_overflow();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_bcd_ctrl.md
KEYPAD_BCD_CTRL -- requirements
Module: keypad_bcd_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the number of consecutive stable samples needed to accept a press or release; legal range 2..255.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of buffered BCD codes; legal values are powers of two, 2..16.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_en  input  1  scan enable; low forces the FSM to IDLE and blocks pushes.
REQ-006 i_keys  input  10  raw decimal key lines; bit n high means key n is pressed; asynchronous to i_clk.
REQ-007 i_ready  input  1  consumer accepts the head code when high together with o_valid.
REQ-008 o_valid  output  1  FIFO non-empty.
REQ-009 o_bcd  output  4  head-of-FIFO BCD code (0..9), show-ahead; 4'b0000 when empty.
REQ-010 o_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-011 o_err  output  1  one-cycle pulse: stable multi-key (non-one-hot) press rejected.
REQ-012 o_ovf  output  1  one-cycle pulse: valid code dropped because the FIFO was full.

Function
REQ-013 i_keys SHALL pass through a 2-flop synchronizer (s1, s2); all FSM decisions SHALL use s2.
REQ-014 The FSM SHALL have three states: IDLE, DEBOUNCE and HOLD, plus a debounce counter and a 10-bit capture register.
REQ-015 IDLE: if i_en=1 and s2!=0, the FSM SHALL go to DEBOUNCE with capture<=s2 and cnt<=1; otherwise it stays in IDLE.
REQ-016 DEBOUNCE: if s2==capture and cnt==DEBOUNCE_CYCLES-1, the FSM SHALL evaluate the capture and go to HOLD; if s2==capture and cnt is lower, cnt SHALL increment.
REQ-017 DEBOUNCE: if s2!=capture and s2!=0, the FSM SHALL set capture<=s2 and cnt<=1; if s2==0, it SHALL return to IDLE.
REQ-018 Evaluation of a one-hot capture SHALL push its index as BCD (bit n -> n; bit 0 -> 0000, bit 9 -> 1001).
REQ-019 Evaluation of a non-one-hot capture SHALL assert o_err for exactly one cycle and SHALL NOT push.
REQ-020 HOLD: the FSM SHALL return to IDLE after s2==0 for DEBOUNCE_CYCLES consecutive cycles; any nonzero s2 resets that count; one press yields at most one push.
REQ-021 i_en=0 SHALL force the FSM to IDLE and the counter to 0 on the next edge; it SHALL NOT affect FIFO contents or popping.
REQ-022 A pop SHALL occur on an edge where o_valid=1 and i_ready=1; i_ready while empty SHALL be ignored.
REQ-023 A push SHALL be accepted if o_count<FIFO_DEPTH, or if a pop occurs in the same cycle (full FIFO with simultaneous push and pop: count unchanged, order preserved).
REQ-024 Otherwise the push SHALL be dropped, with o_ovf asserted for one cycle and FIFO contents unchanged.
REQ-025 FIFO SHALL be first-in first-out with wrapping read/write pointers; o_valid and o_bcd SHALL change only on clock edges.
REQ-026 Latency: keys stable before edge 1 SHALL be pushed on edge DEBOUNCE_CYCLES+2, with o_valid high after that edge (edge 6 at default).

Reset
REQ-027 While i_rst=1, without waiting for a clock edge, the block SHALL hold:
- FSM=IDLE, cnt=0, capture=0, s1=s2=0;
- FIFO empty with pointers 0;
- o_valid=0, o_bcd=0, o_count=0, o_err=0, o_ovf=0.
REQ-028 Reset asserted mid-debounce or mid-hold SHALL discard the pending press; the first press after deassertion SHALL follow REQ-026 timing.

Verification
REQ-029 Key 7 held, i_ready=0 -> o_valid rises after edge 6, o_bcd=0111, o_count=1; no further push while held.
REQ-030 Key 3 glitching high for 2 cycles, then released -> no push, o_err=0, FSM back in IDLE.
REQ-031 Keys 2 and 5 held together -> one o_err pulse at edge 6, o_count stays 0; after release and key 9, o_bcd=1001.
REQ-032 Presses 1,2,3,4 with i_ready=0, then a 5th press 6 -> o_count=4, one o_ovf pulse; then i_ready=1 drains 0001, 0010, 0011, 0100.
REQ-033 Full FIFO with i_ready=1 on the push edge of key 8 -> no o_ovf, o_count stays 4, and 1000 is drained last.
REQ-034 i_rst pulsed mid-debounce while 2 codes are buffered -> o_valid=0 and o_count=0 immediately, with no push from the interrupted press.
